// File: rtl/cache_axi_mem_responder.sv
// Memory-side responder for the cache request channel: serves read bursts from and
// absorbs write bursts into a word-addressed on-chip array, one transaction at a time.
module cache_axi_mem_responder #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned WR_RESP_LAT = 1
) (
    input  logic        clk,
    input  logic        rstn,
    // read request / beat channel
    input  logic        r_req,
    input  logic [31:0] r_addr,
    input  logic [7:0]  r_length,
    input  logic [2:0]  r_size,
    output logic        r_rdy,
    output logic [31:0] r_data,
    output logic        r_data_valid,
    output logic        r_data_last,
    input  logic        r_data_ready,
    // write request / beat channel
    input  logic        w_req,
    input  logic [31:0] w_addr,
    input  logic [7:0]  w_length,
    input  logic [2:0]  w_size,
    output logic        w_rdy,
    input  logic [31:0] w_data,
    input  logic [3:0]  w_strb,
    input  logic        w_data_valid,
    input  logic        w_data_last,
    output logic        w_data_ready,
    output logic        w_done,
    output logic        proto_err
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam int unsigned AW2     = ADDR_W + 2;
    localparam int unsigned LAT_MAX = (RD_LAT > WR_RESP_LAT) ? RD_LAT : WR_RESP_LAT;
    localparam int unsigned CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    // Terminal counts: R_WAIT spends RD_LAT-1 cycles; W_RESP raises w_done after WR_RESP_LAT-1.
    localparam logic [CNT_W-1:0] RD_WAIT = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_WAIT = CNT_W'((WR_RESP_LAT > 1) ? (WR_RESP_LAT - 2) : 0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        R_WAIT  = 3'd1,
        R_BURST = 3'd2,
        W_BURST = 3'd3,
        W_RESP  = 3'd4
    } state_t;

    logic [31:0] mem [DEPTH];

    state_t           state_q, state_d;
    logic [AW2-1:0]   addr_q, addr_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       beat_q, beat_d;
    logic [1:0]       size_q, size_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        r_rdy_d, r_data_valid_d, r_data_last_d;
    logic [31:0] r_data_d;
    logic        w_rdy_d, w_data_ready_d, w_done_d, proto_err_d;

    logic [AW2-1:0]    addr_next_c;
    logic [ADDR_W-1:0] rd_idx_c;
    logic [ADDR_W-1:0] wr_idx_c;
    logic [31:0]       rd_word_c;
    logic              mem_we_c;
    logic              final_beat_c;

    // Only the word-index bits of the byte address reach the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{r_addr[31:AW2], w_addr[31:AW2]};

    // Beat sizes above a word behave as word beats.
    function automatic logic [1:0] clamp_size(input logic [2:0] s);
        return (s > 3'd2) ? 2'd2 : s[1:0];
    endfunction

    // Address stepping and array read port; during a burst the next beat is fetched ahead.
    assign addr_next_c  = addr_q + (AW2'(1) << size_q);
    assign rd_idx_c     = (state_q == R_BURST) ? addr_next_c[AW2-1:2] : addr_q[AW2-1:2];
    assign wr_idx_c     = addr_q[AW2-1:2];
    assign rd_word_c    = mem[rd_idx_c];
    assign final_beat_c = (beat_q == len_q);

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        len_d          = len_q;
        beat_d         = beat_q;
        size_d         = size_q;
        cnt_d          = cnt_q;
        r_rdy_d        = 1'b0;
        r_data_d       = r_data;
        r_data_valid_d = r_data_valid;
        r_data_last_d  = r_data_last;
        w_rdy_d        = 1'b0;
        w_data_ready_d = w_data_ready;
        w_done_d       = 1'b0;
        proto_err_d    = proto_err;
        mem_we_c       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Write wins so a victim line is written back before its refill is read.
                if (w_req) begin
                    w_rdy_d        = 1'b1;
                    w_data_ready_d = 1'b1;
                    addr_d         = w_addr[AW2-1:0];
                    len_d          = w_length;
                    size_d         = clamp_size(w_size);
                    beat_d         = 8'd0;
                    state_d        = W_BURST;
                end else if (r_req) begin
                    r_rdy_d = 1'b1;
                    addr_d  = r_addr[AW2-1:0];
                    len_d   = r_length;
                    size_d  = clamp_size(r_size);
                    beat_d  = 8'd0;
                    cnt_d   = '0;
                    state_d = R_WAIT;
                end
            end

            R_WAIT: begin
                if (cnt_q == RD_WAIT) begin
                    r_data_d       = rd_word_c;
                    r_data_valid_d = 1'b1;
                    r_data_last_d  = (len_q == 8'd0);
                    state_d        = R_BURST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            R_BURST: begin
                // Outputs hold while the initiator stalls.
                if (r_data_ready) begin
                    if (final_beat_c) begin
                        r_data_valid_d = 1'b0;
                        r_data_last_d  = 1'b0;
                        state_d        = IDLE;
                    end else begin
                        beat_d        = beat_q + 8'd1;
                        addr_d        = addr_next_c;
                        r_data_d      = rd_word_c;
                        r_data_last_d = ((beat_q + 8'd1) == len_q);
                    end
                end
            end

            W_BURST: begin
                if (w_data_valid) begin
                    mem_we_c = 1'b1;
                    // The beat count decides termination; a disagreeing last flag is only flagged.
                    if (w_data_last != final_beat_c) begin
                        proto_err_d = 1'b1;
                    end
                    if (final_beat_c) begin
                        w_data_ready_d = 1'b0;
                        cnt_d          = '0;
                        w_done_d       = (WR_RESP_LAT == 1);
                        state_d        = W_RESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                        addr_d = addr_next_c;
                    end
                end
            end

            W_RESP: begin
                // Leave only after the w_done cycle so no request is accepted alongside it.
                if (w_done) begin
                    state_d = IDLE;
                end else if (cnt_q == WR_WAIT) begin
                    w_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d        = IDLE;
                r_data_valid_d = 1'b0;
                r_data_last_d  = 1'b0;
                w_data_ready_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears every handshake output immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            size_q       <= '0;
            cnt_q        <= '0;
            r_rdy        <= 1'b0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_data_last  <= 1'b0;
            w_rdy        <= 1'b0;
            w_data_ready <= 1'b0;
            w_done       <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            size_q       <= size_d;
            cnt_q        <= cnt_d;
            r_rdy        <= r_rdy_d;
            r_data       <= r_data_d;
            r_data_valid <= r_data_valid_d;
            r_data_last  <= r_data_last_d;
            w_rdy        <= w_rdy_d;
            w_data_ready <= w_data_ready_d;
            w_done       <= w_done_d;
            proto_err    <= proto_err_d;
        end
    end

    // Byte-lane write into the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) begin
                    mem[wr_idx_c][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_axi_mem_responder.sv
// Directed bench for cache_axi_mem_responder: table of single-beat write/read vectors
// plus hand-written burst, stall, arbitration, protocol-error, reset and wrap sequences.
module tb_cache_axi_mem_responder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        r_req;
    logic [31:0] r_addr;
    logic [7:0]  r_length;
    logic [2:0]  r_size;
    logic        r_rdy;
    logic [31:0] r_data;
    logic        r_data_valid;
    logic        r_data_last;
    logic        r_data_ready;
    logic        w_req;
    logic [31:0] w_addr;
    logic [7:0]  w_length;
    logic [2:0]  w_size;
    logic        w_rdy;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_data_valid;
    logic        w_data_last;
    logic        w_data_ready;
    logic        w_done;
    logic        proto_err;

    cache_axi_mem_responder #(
        .ADDR_W      (12),
        .RD_LAT      (2),
        .WR_RESP_LAT (1)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .r_req        (r_req),
        .r_addr       (r_addr),
        .r_length     (r_length),
        .r_size       (r_size),
        .r_rdy        (r_rdy),
        .r_data       (r_data),
        .r_data_valid (r_data_valid),
        .r_data_last  (r_data_last),
        .r_data_ready (r_data_ready),
        .w_req        (w_req),
        .w_addr       (w_addr),
        .w_length     (w_length),
        .w_size       (w_size),
        .w_rdy        (w_rdy),
        .w_data       (w_data),
        .w_strb       (w_strb),
        .w_data_valid (w_data_valid),
        .w_data_last  (w_data_last),
        .w_data_ready (w_data_ready),
        .w_done       (w_done),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] wr_data [16];
    logic [31:0] rd_got  [16];

    typedef struct {
        logic [31:0] waddr;
        logic [2:0]  wsize;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write burst of wr_data[0..len]; w_data_last is raised on beat last_at.
    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [3:0] strb, input int last_at);
        int guard;
        w_addr   = addr;
        w_length = len;
        w_size   = size;
        w_req    = 1'b1;
        guard    = 0;
        do begin
            tick();
            guard++;
        end while (!w_rdy && guard < 20);
        check("w_rdy", 32'(w_rdy), 32'd1);
        check("r_rdy_during_w_rdy", 32'(r_rdy), 32'd0);
        w_req = 1'b0;
        check("w_data_ready", 32'(w_data_ready), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            w_data       = wr_data[i];
            w_strb       = strb;
            w_data_valid = 1'b1;
            w_data_last  = (i == last_at);
            tick();
            if (i == 0) check("w_rdy_pulse", 32'(w_rdy), 32'd0);
        end
        w_data_valid = 1'b0;
        w_data_last  = 1'b0;
        check("w_done", 32'(w_done), 32'd1);
        check("w_data_ready_end", 32'(w_data_ready), 32'd0);
        tick();
        check("w_done_pulse", 32'(w_done), 32'd0);
    endtask

    // Read burst into rd_got; optional 1010 ready pattern; returns early at beat abort_at.
    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                              input bit toggle, input int abort_at, output bit aborted);
        int          guard;
        int          n;
        int          cyc;
        bit          stalled;
        logic [31:0] held;
        aborted  = 1'b0;
        r_addr   = addr;
        r_length = len;
        r_size   = size;
        r_req    = 1'b1;
        guard    = 0;
        do begin
            tick();
            guard++;
        end while (!r_rdy && guard < 40);
        check("r_rdy", 32'(r_rdy), 32'd1);
        r_req        = 1'b0;
        r_data_ready = 1'b0;
        tick();
        check("r_rdy_pulse", 32'(r_rdy), 32'd0);
        check("r_valid_early", 32'(r_data_valid), 32'd0);
        tick();
        check("r_valid_latency", 32'(r_data_valid), 32'd1);
        n       = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (n <= int'(len) && cyc < 200) begin
            if (n == abort_at && r_data_valid) begin
                aborted = 1'b1;
                return;
            end
            r_data_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (r_data_valid) begin
                if (stalled) check("r_hold", r_data, held);
                if (r_data_ready) begin
                    rd_got[n] = r_data;
                    check("r_last", 32'(r_data_last), 32'(n == int'(len)));
                    n++;
                    stalled = 1'b0;
                end else begin
                    held    = r_data;
                    stalled = 1'b1;
                end
            end
            tick();
            cyc++;
        end
        r_data_ready = 1'b0;
        check("r_beats", 32'(n), 32'(int'(len) + 1));
        check("r_valid_after", 32'(r_data_valid), 32'd0);
    endtask

    initial begin
        bit ab;

        vecs[0] = '{32'h200,  3'd2, 4'b1111, 32'h1122_3344, 32'h200,  32'h1122_3344};
        vecs[1] = '{32'h203,  3'd0, 4'b1000, 32'hAA00_0000, 32'h200,  32'hAA22_3344};
        vecs[2] = '{32'h200,  3'd1, 4'b0011, 32'h0000_BEEF, 32'h200,  32'hAA22_BEEF};
        vecs[3] = '{32'h201,  3'd0, 4'b0010, 32'h0000_5500, 32'h200,  32'hAA22_55EF};
        vecs[4] = '{32'h204,  3'd2, 4'b1111, 32'hCAFE_F00D, 32'h204,  32'hCAFE_F00D};
        vecs[5] = '{32'h204,  3'd2, 4'b0000, 32'hFFFF_FFFF, 32'h206,  32'hCAFE_F00D};
        vecs[6] = '{32'h3FFC, 3'd2, 4'b1111, 32'h1234_5678, 32'h3FFC, 32'h1234_5678};
        vecs[7] = '{32'h200,  3'd7, 4'b0100, 32'h0077_0000, 32'h203,  32'hAA77_55EF};

        rstn = 1'b0;
        r_req = 1'b0; r_addr = '0; r_length = '0; r_size = '0; r_data_ready = 1'b0;
        w_req = 1'b0; w_addr = '0; w_length = '0; w_size = '0;
        w_data = '0; w_strb = '0; w_data_valid = 1'b0; w_data_last = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_r_rdy", 32'(r_rdy), 32'd0);
        check("rst_r_data", r_data, 32'd0);
        check("rst_r_valid", 32'(r_data_valid), 32'd0);
        check("rst_r_last", 32'(r_data_last), 32'd0);
        check("rst_w_rdy", 32'(w_rdy), 32'd0);
        check("rst_w_data_ready", 32'(w_data_ready), 32'd0);
        check("rst_w_done", 32'(w_done), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        #2 rstn = 1'b1;
        tick();

        // Preload line at word 0x40 with 0..15, then refill it with ready held high
        for (int i = 0; i < 16; i++) wr_data[i] = 32'(i);
        write_burst(32'h100, 8'd15, 3'd2, 4'hF, 15);
        read_burst(32'h100, 8'd15, 3'd2, 1'b0, -1, ab);
        for (int i = 0; i < 16; i++) check($sformatf("t1_beat%0d", i), rd_got[i], 32'(i));

        // Same refill with ready toggling 1010..
        read_burst(32'h100, 8'd15, 3'd2, 1'b1, -1, ab);
        for (int i = 0; i < 16; i++) check($sformatf("t2_beat%0d", i), rd_got[i], 32'(i));

        // Table of single-beat writes followed by single-beat reads
        foreach (vecs[i]) begin
            wr_data[0] = vecs[i].wdata;
            write_burst(vecs[i].waddr, 8'd0, vecs[i].wsize, vecs[i].strb, 0);
            read_burst(vecs[i].raddr, 8'd0, 3'd0, 1'b0, -1, ab);
            check($sformatf("vec%0d", i), rd_got[0], vecs[i].exp);
        end

        // Simultaneous read and write requests to the same line: write first
        for (int i = 0; i < 16; i++) wr_data[i] = 32'hC0DE_0000 | 32'(i);
        r_addr = 32'h100; r_length = 8'd15; r_size = 3'd2; r_req = 1'b1;
        write_burst(32'h100, 8'd15, 3'd2, 4'hF, 15);
        read_burst(32'h100, 8'd15, 3'd2, 1'b0, -1, ab);
        for (int i = 0; i < 16; i++) check($sformatf("t4_beat%0d", i), rd_got[i], 32'hC0DE_0000 | 32'(i));

        // Early w_data_last on beat 3: sticky error, all beats still written
        check("t5_err_before", 32'(proto_err), 32'd0);
        for (int i = 0; i < 16; i++) wr_data[i] = 32'h0000_5000 + 32'(i);
        write_burst(32'h300, 8'd15, 3'd2, 4'hF, 3);
        check("t5_err_after", 32'(proto_err), 32'd1);
        read_burst(32'h300, 8'd15, 3'd2, 1'b0, -1, ab);
        for (int i = 0; i < 16; i++) check($sformatf("t5_beat%0d", i), rd_got[i], 32'h0000_5000 + 32'(i));
        check("t5_err_sticky", 32'(proto_err), 32'd1);

        // Reset during read beat 5, then a fresh single-beat read
        read_burst(32'h300, 8'd15, 3'd2, 1'b0, 5, ab);
        check("t6_aborted", 32'(ab), 32'd1);
        rstn = 1'b0;
        #1;
        check("t6_r_valid", 32'(r_data_valid), 32'd0);
        check("t6_r_data", r_data, 32'd0);
        check("t6_r_last", 32'(r_data_last), 32'd0);
        check("t6_r_rdy", 32'(r_rdy), 32'd0);
        check("t6_w_data_ready", 32'(w_data_ready), 32'd0);
        check("t6_proto_err", 32'(proto_err), 32'd0);
        #2 rstn = 1'b1;
        r_data_ready = 1'b0;
        tick();
        read_burst(32'h304, 8'd0, 3'd2, 1'b0, -1, ab);
        check("t6_fresh_read", rd_got[0], 32'h0000_5001);

        // Burst that wraps from the top word to word 0
        wr_data[0] = 32'hDEAD_0001;
        wr_data[1] = 32'hDEAD_0002;
        write_burst(32'h3FFC, 8'd1, 3'd2, 4'hF, 1);
        read_burst(32'h3FFC, 8'd1, 3'd2, 1'b0, -1, ab);
        check("t7_top", rd_got[0], 32'hDEAD_0001);
        check("t7_wrap", rd_got[1], 32'hDEAD_0002);
        read_burst(32'h0, 8'd0, 3'd2, 1'b0, -1, ab);
        check("t7_word0", rd_got[0], 32'hDEAD_0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound the whole run
    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
